// File: rtl/dm_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes and sweep states.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_READY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: merges sub-word store data into a word and
// extracts/extends sub-word load data (little-endian lanes).
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wd,
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sign_ext,
    output logic [31:0] o_merged,
    output logic [31:0] o_rd
);

    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] wd,
                                          input size_e       sz,
                                          input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (sz)
            SZ_BYTE: w[{lane, 3'b000} +: 8]     = wd[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wd[15:0];
            SZ_WORD: w = wd;
            default: w = old_word;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input size_e       sz,
                                            input logic [1:0]  lane,
                                            input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: return sx ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: return sx ? {{16{h[15]}}, h} : {16'd0, h};
            SZ_WORD: return word;
            default: return 32'd0;
        endcase
    endfunction

    assign o_merged = merge(i_word, i_wd, i_size, i_lane);
    assign o_rd     = extract(i_word, i_size, i_lane, i_sign_ext);

endmodule

// File: rtl/data_mem_be.sv
// M-stage byte-addressable data memory: combinational reads, clocked
// lane-merged writes, error detection and a post-reset zeroing sweep.
module data_mem_be
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int TRACE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rd,
    output logic        busy,
    output logic        addr_err
);

    logic [31:0]       r_mem [2**ADDR_W];
    dm_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_idx;

    size_e             w_size;
    logic [ADDR_W-1:0] w_idx;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_we;
    logic [31:0]       w_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_extracted;

    assign w_size = size_e'(size);
    assign w_idx  = addr[ADDR_W+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = addr[0];
            SZ_WORD: w_misaligned = |addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_out_of_range = |(addr >> (ADDR_W + 2));
    assign addr_err       = w_misaligned | w_out_of_range;
    assign busy           = (r_state == DM_CLEAR);
    assign w_we           = mem_write & ~addr_err & ~busy;
    assign rd             = (addr_err | busy) ? 32'd0 : w_extracted;

    dm_lane_align u_lane_align (
        .i_word     (w_word),
        .i_wd       (wd),
        .i_size     (w_size),
        .i_lane     (addr[1:0]),
        .i_sign_ext (sign_ext),
        .o_merged   (w_merged),
        .o_rd       (w_extracted)
    );

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= DM_CLEAR;
            r_clr_idx <= '0;
        end else begin
            case (r_state)
                DM_CLEAR: begin
                    if (r_clr_idx == '1)
                        r_state <= DM_READY;
                    r_clr_idx <= r_clr_idx + 1'b1;
                end
                default: r_state <= DM_READY;
            endcase
        end
    end

    // NOTE: the array has no reset; zeroing is done one word per cycle by the sweep.
    always_ff @(posedge clk) begin
        if (r_state == DM_CLEAR) begin
            r_mem[r_clr_idx] <= 32'd0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_merged;
`ifndef SYNTHESIS
            if (TRACE != 0)
                $display("%0t@%h: *%h <= %h", $time, pc_m, {addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_be.sv
// Self-checking bench for data_mem_be: directed test-plan cases plus random
// traffic compared against a byte-array reference model.
module tb_data_mem_be;

    localparam int AW     = 10;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rd;
    logic        busy;
    logic        addr_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] m_mem [NBYTES];

    data_mem_be #(.ADDR_W(AW), .TRACE(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_m      (pc_m),
        .addr      (addr),
        .wd        (wd),
        .mem_write (mem_write),
        .size      (size),
        .sign_ext  (sign_ext),
        .rd        (rd),
        .busy      (busy),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
        int n;
        n = nb(sz);
        if (n == 0) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        return a >= NBYTES;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int n;
        if (m_err(a, sz)) return 32'd0;
        n = nb(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(m_mem[a + i]) << (8 * i));
        if (n < 4 && sx && v[8 * n - 1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nb(sz); i++)
            m_mem[a + i] = d[8 * i +: 8];
    endtask

    task automatic m_clear();
        for (int i = 0; i < NBYTES; i++)
            m_mem[i] = 8'd0;
    endtask

    // One cycle of traffic with the memory READY: checks pre-edge outputs, then commits to the model.
    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                      input logic sx, input logic we);
        logic exp_err;
        @(negedge clk);
        addr = a; wd = d; size = sz; sign_ext = sx; mem_write = we; pc_m = pc_m + 32'd4;
        exp_err = m_err(a, sz);
        #1;
        check("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        check("rd", rd, m_load(a, sz, sx));
        @(posedge clk);
        #1 mem_write = 1'b0;
        if (we && !exp_err) m_store(a, sz, d);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] exp);
        @(negedge clk);
        addr = a; size = sz; sign_ext = sx; mem_write = 1'b0;
        #1 check(tag, rd, exp);
    endtask

    task automatic wait_sweep(input string tag);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (busy && cycles < 3000);
        check(tag, 32'(cycles), 32'(NWORDS));
        m_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc_m = 32'h0040_0000; addr = 32'd0; wd = 32'd0;
        mem_write = 1'b0; size = 2'b10; sign_ext = 1'b0;

        // Reset state: busy high, rd zero, addr_err purely combinational
        repeat (2) @(negedge clk);
        addr = 32'h10; size = 2'b10;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd", rd, 32'd0);
        check("reset_err_ok", {31'd0, addr_err}, 32'd0);
        addr = 32'h13;
        #1 check("reset_err_mis", {31'd0, addr_err}, 32'd1);
        @(negedge clk) reset = 1'b0;
        wait_sweep("sweep_len_init");

        // Preload nonzero data across the whole array
        for (int i = 0; i < 200; i++)
            op(32'($urandom_range(0, NWORDS - 1)) * 4, $urandom | 32'd1, 2'b10, 1'b0, 1'b1);

        // Sub-word stores and extension
        op(32'h10, 32'h1122_3344, 2'b10, 1'b0, 1'b1);
        op(32'h11, 32'h1234_56AA, 2'b00, 1'b0, 1'b1);
        op(32'h12, 32'hCAFE_BEEF, 2'b01, 1'b0, 1'b1);
        load("lw_0x10", 32'h10, 2'b10, 1'b0, 32'hBEEF_AA44);
        load("lb_0x11", 32'h11, 2'b00, 1'b1, 32'hFFFF_FFAA);
        load("lbu_0x11", 32'h11, 2'b00, 1'b0, 32'h0000_00AA);
        load("lhu_0x12", 32'h12, 2'b01, 1'b0, 32'h0000_BEEF);
        load("lh_0x12", 32'h12, 2'b01, 1'b1, 32'hFFFF_BEEF);

        // Misaligned and out-of-range stores are dropped
        op(32'h14, 32'h0000_0000, 2'b10, 1'b0, 1'b1);
        op(32'h13, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1);
        op(32'h15, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b1);
        load("mis_keep_0x10", 32'h10, 2'b10, 1'b0, 32'hBEEF_AA44);
        load("mis_keep_0x14", 32'h14, 2'b10, 1'b0, 32'h0000_0000);
        load("rsvd_size_rd", 32'h10, 2'b11, 1'b0, 32'h0000_0000);
        op(32'h0, 32'h0000_1234, 2'b10, 1'b0, 1'b1);
        op(32'h1000, 32'h0000_0077, 2'b10, 1'b0, 1'b1);
        load("range_keep_w0", 32'h0, 2'b10, 1'b0, 32'h0000_1234);

        // Read-during-write shows the old word, new word after the edge
        op(32'h20, 32'h9, 2'b10, 1'b0, 1'b1);
        @(negedge clk);
        addr = 32'h20; wd = 32'h5; size = 2'b10; mem_write = 1'b1;
        #1 check("rdw_old", rd, 32'h9);
        @(posedge clk);
        #1 mem_write = 1'b0;
        check("rdw_new", rd, 32'h5);
        m_store(32'h20, 2'b10, 32'h5);

        // Random traffic in a small window, with occasional wild addresses
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'h100 + 32'($urandom_range(0, 63));
            op(a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        end

        // Reset sweep clears the preloaded array
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        wait_sweep("sweep_len_clear");
        for (int i = 0; i < NWORDS; i++)
            load("cleared", 32'(i) * 4, 2'b10, 1'b0, 32'd0);

        // Store during sweep is dropped; reset at sweep cycle 500 restarts it
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        addr = 32'h0; wd = 32'hFFFF_FFFF; size = 2'b10; mem_write = 1'b1;
        #1;
        check("sweep_busy", {31'd0, busy}, 32'd1);
        check("sweep_rd", rd, 32'd0);
        @(posedge clk);
        #1 mem_write = 1'b0;
        repeat (489) @(posedge clk);
        #1 check("busy_at_500", {31'd0, busy}, 32'd1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        wait_sweep("sweep_len_restart");
        load("busy_store_dropped", 32'h0, 2'b10, 1'b0, 32'd0);

        // Back-to-back mixed-lane stores after the restart
        for (int i = 0; i < 100; i++)
            op(32'h40 + 32'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
